// File: rtl/reg_file_pkg.sv
// Shared helpers for the parametrised register file: address sizing and the
// byte-enable merge used by both the storage cells and the bypass path.
package reg_file_pkg;

    localparam int unsigned MAX_WIDTH = 256;
    localparam int unsigned MAX_BYTES = MAX_WIDTH / 8;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Callers zero-extend narrower words into and truncate back out of MAX_WIDTH.
    function automatic logic [MAX_WIDTH-1:0] byte_merge(
        input logic [MAX_WIDTH-1:0] old_word,
        input logic [MAX_WIDTH-1:0] new_word,
        input logic [MAX_BYTES-1:0] be
    );
        logic [MAX_WIDTH-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/reg_file_param_gen_reg.sv
// Load-enabled register cell with synchronous clear and per-byte write enables.
module gen_reg_param
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               en,
    input  logic [WIDTH/8-1:0] be,
    input  logic [WIDTH-1:0]   d,
    output logic [WIDTH-1:0]   q
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = WIDTH'(byte_merge(MAX_WIDTH'(data_q), MAX_WIDTH'(d), MAX_BYTES'(be)));
        end
    end

    always_ff @(posedge clk) begin
        if (clr) data_q <= '0;
        else     data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/reg_file_param.sv
// Register file: one byte-enabled write port, NUM_RD combinational read ports,
// optional hardwired-zero R0 and optional write-to-read bypass.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned NUM_RD  = 2,
    parameter bit          R0_ZERO = 1'b1,
    parameter bit          BYPASS  = 1'b1,
    localparam int unsigned AW     = addr_width(DEPTH)
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [WIDTH/8-1:0]      wr_be,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [DEPTH-1:0]        wr_busy
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] wr_busy_q;
    logic [DEPTH-1:0] wr_busy_d;
    logic [WIDTH-1:0] wr_merged;
    logic [AW-1:0]    rd_idx;
    logic [WIDTH-1:0] rd_lane;

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (R0_ZERO && i == 0) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_cell
            gen_reg_param #(.WIDTH(WIDTH)) u_reg (
                .clk (clk),
                .clr (clr),
                .en  (wr_en && (wr_addr == AW'(i))),
                .be  (wr_be),
                .d   (wr_data),
                .q   (regs[i])
            );
        end
    end

    always_comb begin
        wr_busy_d = '0;
        if (wr_en && !(R0_ZERO && wr_addr == '0)) wr_busy_d[wr_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr) wr_busy_q <= '0;
        else     wr_busy_q <= wr_busy_d;
    end

    assign wr_busy = wr_busy_q;

    // Same merge the storage cell will commit at the edge, so bypassed reads match.
    always_comb begin
        wr_merged = WIDTH'(byte_merge(MAX_WIDTH'(regs[wr_addr]), MAX_WIDTH'(wr_data),
                                      MAX_BYTES'(wr_be)));
    end

    always_comb begin
        rd_data = '0;
        rd_idx  = '0;
        rd_lane = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_idx  = rd_addr[k*AW +: AW];
            rd_lane = regs[rd_idx];
            if (BYPASS && wr_en && !clr && rd_idx == wr_addr) rd_lane = wr_merged;
            if (R0_ZERO && rd_idx == '0) rd_lane = '0;
            rd_data[k*WIDTH +: WIDTH] = rd_lane;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default build, a no-bypass build and a
// 16-bit / 8-entry / 3-port build, all with hand-computed expected values.
module tb_reg_file_param;

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: defaults (bypass on)
    logic        a_wr_en = 1'b0;
    logic [3:0]  a_wr_addr = '0;
    logic [3:0]  a_wr_be = '0;
    logic [31:0] a_wr_data = '0;
    logic [7:0]  a_rd_addr = '0;
    logic [63:0] a_rd_data;
    logic [15:0] a_busy;

    // Instance B: bypass off
    logic        b_wr_en = 1'b0;
    logic [3:0]  b_wr_addr = '0;
    logic [3:0]  b_wr_be = '0;
    logic [31:0] b_wr_data = '0;
    logic [7:0]  b_rd_addr = '0;
    logic [63:0] b_rd_data;
    logic [15:0] b_busy;

    // Instance C: WIDTH=16, DEPTH=8, NUM_RD=3
    logic        c_wr_en = 1'b0;
    logic [2:0]  c_wr_addr = '0;
    logic [1:0]  c_wr_be = '0;
    logic [15:0] c_wr_data = '0;
    logic [8:0]  c_rd_addr = '0;
    logic [47:0] c_rd_data;
    logic [7:0]  c_busy;

    reg_file_param u_a (
        .clk(clk), .clr(clr), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_be(a_wr_be),
        .wr_data(a_wr_data), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .wr_busy(a_busy)
    );

    reg_file_param #(.BYPASS(1'b0)) u_b (
        .clk(clk), .clr(clr), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_be(b_wr_be),
        .wr_data(b_wr_data), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .wr_busy(b_busy)
    );

    reg_file_param #(.WIDTH(16), .DEPTH(8), .NUM_RD(3)) u_c (
        .clk(clk), .clr(clr), .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_be(c_wr_be),
        .wr_data(c_wr_data), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .wr_busy(c_busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data; a_wr_be = be;
    endtask

    initial begin
        // Reset everything
        clr = 1'b1;
        tick();
        clr = 1'b0;
        a_rd_addr = {4'd3, 4'd3};
        #1;
        check_eq("reset_rd", a_rd_data, 64'h0);
        check_eq("reset_busy", a_busy, 16'h0);

        // Preload R3 then clear
        a_write(4'd3, 32'hDEADBEEF, 4'hF);
        tick();
        a_wr_en = 1'b0;
        #1;
        check_eq("preload_r3", a_rd_data, 64'hDEADBEEF_DEADBEEF);
        check_eq("preload_busy", a_busy, 16'h0008);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1;
        check_eq("clr_r3", a_rd_data, 64'h0);
        check_eq("clr_busy", a_busy, 16'h0);

        // Full write R5
        a_write(4'd5, 32'h12345678, 4'hF);
        tick();
        a_wr_en = 1'b0;
        a_rd_addr = {4'd3, 4'd5};
        #1;
        check_eq("full_r5", a_rd_data[31:0], 32'h12345678);
        check_eq("full_busy", a_busy, 16'h0020);
        tick();
        check_eq("full_busy_drop", a_busy, 16'h0);

        // Byte merge
        a_write(4'd5, 32'hAABBCCDD, 4'b0101);
        tick();
        a_wr_en = 1'b0;
        #1;
        check_eq("merge_r5", a_rd_data[31:0], 32'h12BB56DD);

        // R0 hardwired zero, including while a write to R0 is in flight
        a_write(4'd0, 32'hFFFFFFFF, 4'hF);
        a_rd_addr = {4'd0, 4'd5};
        #1;
        check_eq("r0_bypass", a_rd_data[63:32], 32'h0);
        tick();
        a_wr_en = 1'b0;
        #1;
        check_eq("r0_read", a_rd_data[63:32], 32'h0);
        check_eq("r0_busy", a_busy, 16'h0);

        // clr beats wr_en
        a_write(4'd7, 32'h00000055, 4'hF);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        a_wr_en = 1'b0;
        a_rd_addr = {4'd7, 4'd7};
        #1;
        check_eq("clr_prio_r7", a_rd_data, 64'h0);
        check_eq("clr_prio_busy", a_busy, 16'h0);

        // Bypass vs no bypass
        a_write(4'd2, 32'h11111111, 4'hF);
        b_wr_en = 1'b1; b_wr_addr = 4'd2; b_wr_data = 32'h11111111; b_wr_be = 4'hF;
        tick();
        a_write(4'd2, 32'h22222222, 4'b0011);
        b_wr_data = 32'h22222222; b_wr_be = 4'b0011;
        a_rd_addr = {4'd2, 4'd7};
        b_rd_addr = {4'd2, 4'd7};
        #1;
        check_eq("bypass_on", a_rd_data[63:32], 32'h11112222);
        check_eq("bypass_off", b_rd_data[63:32], 32'h11111111);
        tick();
        a_wr_en = 1'b0;
        b_wr_en = 1'b0;
        #1;
        check_eq("bypass_on_after", a_rd_data[63:32], 32'h11112222);
        check_eq("bypass_off_after", b_rd_data[63:32], 32'h11112222);

        // Bypass suppressed while clr is high
        a_write(4'd2, 32'h33333333, 4'hF);
        clr = 1'b1;
        #1;
        check_eq("bypass_clr", a_rd_data[63:32], 32'h11112222);
        tick();
        clr = 1'b0;
        a_wr_en = 1'b0;
        #1;
        check_eq("bypass_clr_after", a_rd_data[63:32], 32'h0);

        // Back-to-back busy movement and all-zero byte enables
        a_write(4'd1, 32'hCAFEF00D, 4'hF);
        tick();
        check_eq("b2b_busy1", a_busy, 16'h0002);
        a_write(4'd4, 32'h01020304, 4'hF);
        tick();
        check_eq("b2b_busy4", a_busy, 16'h0010);
        a_write(4'd6, 32'hFFFFFFFF, 4'h0);
        tick();
        a_wr_en = 1'b0;
        a_rd_addr = {4'd6, 4'd1};
        #1;
        check_eq("be0_busy", a_busy, 16'h0040);
        check_eq("be0_data", a_rd_data, {32'h0, 32'hCAFEF00D});
        tick();
        check_eq("b2b_busy_idle", a_busy, 16'h0);

        // Narrow three-port build: R0..R7 written with index*0x0101 (R0 stays zero)
        for (int i = 0; i < 8; i++) begin
            c_wr_en = 1'b1;
            c_wr_addr = 3'(i);
            c_wr_be = 2'b11;
            c_wr_data = 16'(i * 16'h0101);
            tick();
        end
        c_wr_en = 1'b0;
        c_rd_addr = {3'd7, 3'd3, 3'd1};
        #1;
        check_eq("c_lanes_a", c_rd_data, {16'h0707, 16'h0303, 16'h0101});
        c_rd_addr = {3'd0, 3'd6, 3'd2};
        #1;
        check_eq("c_lanes_b", c_rd_data, {16'h0000, 16'h0606, 16'h0202});
        c_wr_en = 1'b1; c_wr_addr = 3'd4; c_wr_be = 2'b10; c_wr_data = 16'hABCD;
        c_rd_addr = {3'd4, 3'd5, 3'd4};
        #1;
        check_eq("c_bypass", c_rd_data, {16'hAB04, 16'h0505, 16'hAB04});
        tick();
        c_wr_en = 1'b0;
        #1;
        check_eq("c_busy", c_busy, 8'h10);
        check_eq("c_after", c_rd_data, {16'hAB04, 16'h0505, 16'hAB04});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
